// File: rtl/gate_code_pkg.sv
// gate_code_pkg: function codes, truth tables and FSM states for the gate code identifier
package gate_code_pkg;
  localparam logic [1:0] CODE_XOR3  = 2'b00;
  localparam logic [1:0] CODE_NAND3 = 2'b01;
  localparam logic [1:0] CODE_NOR3  = 2'b10;
  localparam logic [1:0] CODE_XNOR3 = 2'b11;
  localparam logic [7:0] TT_XOR3  = 8'h96;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XNOR3 = 8'h69;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DECIDE = ST_DECIDE} state_e;
  // {valid, code}; tables are distinct so the priority order is irrelevant
  function automatic logic [2:0] match_code(input logic [7:0] t);
    return t == TT_XOR3  ? {1'b1, CODE_XOR3}  :
           t == TT_NAND3 ? {1'b1, CODE_NAND3} :
           t == TT_NOR3  ? {1'b1, CODE_NOR3}  :
           t == TT_XNOR3 ? {1'b1, CODE_XNOR3} : 3'b000;
  endfunction
endpackage

// File: rtl/gate_code_identifier_v.sv
// gate_code_identifier_v: sweeps all 8 input vectors into a gate and identifies its function code
module gate_code_identifier_v
  import gate_code_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_f,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic [7:0] o_observed
);
  localparam int CW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
  state_e          state_q;
  logic [2:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, valid_q;
  logic [1:0]      code_q;
  logic [7:0]      obs_q;
  logic [2:0]      match_d;
  always_comb match_d = match_code(obs_q);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      obs_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          state_q <= RUN;
          idx_q   <= '0;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          code_q  <= '0;
          obs_q   <= '0;
          busy_q  <= 1'b1;
        end
        RUN: if (cnt_q == CW'(SETTLE_CYCLES)) begin
          obs_q[idx_q] <= i_f;
          cnt_q        <= '0;
          if (idx_q == 3'd7) state_q <= DECIDE;
          else idx_q <= idx_q + 3'd1;
        end else cnt_q <= cnt_q + 1'b1;
        DECIDE: begin
          valid_q <= match_d[2];
          code_q  <= match_d[1:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {o_a, o_b, o_c} = state_q == RUN ? idx_q : 3'b000;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_valid    = valid_q;
  assign o_code     = code_q;
  assign o_observed = obs_q;
endmodule
